// File: rtl/uart_tx.sv
// UART transmitter: start bit, 8 data bits LSB first, optional even parity, one stop bit.
// Define UART_TX_PARITY_EN to insert the even parity bit (11-bit frame instead of 10).
module uart_tx #(
  parameter int unsigned CLOCKS_PER_BIT = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_busy,
  output logic       serial_out
);

  localparam int unsigned CNT_W = (CLOCKS_PER_BIT > 1) ? $clog2(CLOCKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLOCKS_PER_BIT - 1);

  generate
    if (CLOCKS_PER_BIT < 2) begin : g_bad_cpb
      $error("uart_tx: CLOCKS_PER_BIT must be >= 2");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_e;

  state_e           state_q;
  logic [7:0]       shift_q;
  logic [2:0]       bit_cnt_q;
  logic [CNT_W-1:0] cyc_cnt_q;
  logic             serial_q;
  logic             ready_q;
  logic             busy_q;
`ifdef UART_TX_PARITY_EN
  logic             parity_q;
`endif

  logic bit_end;
  assign bit_end = (cyc_cnt_q == CNT_LAST);

  // Frame sequencer; serial_q only changes on bit boundaries so the pad is glitch-free.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      shift_q   <= 8'h00;
      bit_cnt_q <= 3'd0;
      cyc_cnt_q <= '0;
      serial_q  <= 1'b1;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      if (state_q != S_IDLE) begin
        cyc_cnt_q <= bit_end ? '0 : cyc_cnt_q + CNT_W'(1);
      end

      case (state_q)
        S_IDLE: begin
          if (tx_valid) begin
            shift_q   <= tx_data;
            bit_cnt_q <= 3'd0;
            cyc_cnt_q <= '0;
`ifdef UART_TX_PARITY_EN
            parity_q  <= ^tx_data;
`endif
            state_q   <= S_START;
            serial_q  <= 1'b0;
            ready_q   <= 1'b0;
            busy_q    <= 1'b1;
          end
        end

        S_START: begin
          if (bit_end) begin
            state_q  <= S_DATA;
            serial_q <= shift_q[0];
          end
        end

        S_DATA: begin
          if (bit_end) begin
            if (bit_cnt_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              state_q  <= S_PARITY;
              serial_q <= parity_q;
`else
              state_q  <= S_STOP;
              serial_q <= 1'b1;
`endif
            end else begin
              bit_cnt_q <= bit_cnt_q + 3'd1;
              shift_q   <= {1'b0, shift_q[7:1]};
              serial_q  <= shift_q[1];
            end
          end
        end

`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          if (bit_end) begin
            state_q  <= S_STOP;
            serial_q <= 1'b1;
          end
        end
`endif

        S_STOP: begin
          if (bit_end) begin
            state_q <= S_IDLE;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
          end
        end

        default: begin
          state_q  <= S_IDLE;
          serial_q <= 1'b1;
          ready_q  <= 1'b1;
          busy_q   <= 1'b0;
        end
      endcase
    end
  end

  assign tx_ready   = ready_q;
  assign tx_busy    = busy_q;
  assign serial_out = serial_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: frame shape, handshake timing, ignored requests and reset.
module tb_uart_tx;

  localparam int unsigned CPB = 8;
`ifdef UART_TX_PARITY_EN
  localparam bit          PAR = 1'b1;
  localparam int unsigned NB  = 11;
`else
  localparam bit          PAR = 1'b0;
  localparam int unsigned NB  = 10;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_busy;
  logic       serial_out;

  int n_pass   = 0;
  int n_checks = 0;

  uart_tx #(.CLOCKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .reset     (reset),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .tx_busy   (tx_busy),
    .serial_out(serial_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called just after the accept edge; walks the whole frame cycle by cycle.
  task automatic check_frame(input string tag, input logic [7:0] b, input logic pbit,
                             input bit keep_valid, input logic [7:0] new_data,
                             input int pulse_at);
    logic [10:0] all_bits;
    int          idx;
    logic        exp_bit;
    all_bits = {1'b1, pbit, b, 1'b0};
    for (int i = 0; i < int'(NB * CPB); i++) begin
      if (i == 0) begin
        tx_data = new_data;
        if (!keep_valid) tx_valid = 1'b0;
      end
      if (i == pulse_at) begin
        tx_data  = 8'hFF;
        tx_valid = 1'b1;
      end
      if (pulse_at >= 0 && i == pulse_at + 1) tx_valid = 1'b0;
      idx     = i / int'(CPB);
      exp_bit = (!PAR && idx == 9) ? 1'b1 : all_bits[idx];
      check($sformatf("%s_line_c%0d", tag, i), 32'(serial_out), 32'(exp_bit));
      check($sformatf("%s_ready_c%0d", tag, i), 32'(tx_ready), 32'd0);
      check($sformatf("%s_busy_c%0d", tag, i), 32'(tx_busy), 32'd1);
      step();
    end
    check($sformatf("%s_end_ready", tag), 32'(tx_ready), 32'd1);
    check($sformatf("%s_end_busy", tag), 32'(tx_busy), 32'd0);
    check($sformatf("%s_end_line", tag), 32'(serial_out), 32'd1);
  endtask

  initial begin
    // Reset held with a pending request: nothing is accepted, line stays idle.
    reset    = 1'b1;
    tx_valid = 1'b1;
    tx_data  = 8'h55;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("rst_line_%0d", i), 32'(serial_out), 32'd1);
      check($sformatf("rst_ready_%0d", i), 32'(tx_ready), 32'd1);
      check($sformatf("rst_busy_%0d", i), 32'(tx_busy), 32'd0);
    end
    reset = 1'b0;
    step();
    check_frame("f55", 8'h55, 1'b0, 1'b0, 8'h55, -1);

    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("idle_line_%0d", i), 32'(serial_out), 32'd1);
      check($sformatf("idle_ready_%0d", i), 32'(tx_ready), 32'd1);
    end

`ifdef UART_TX_PARITY_EN
    tx_data  = 8'h80;
    tx_valid = 1'b1;
    step();
    check_frame("p80", 8'h80, 1'b1, 1'b0, 8'h80, -1);
    tx_data  = 8'h55;
    tx_valid = 1'b1;
    step();
    check_frame("p55", 8'h55, 1'b0, 1'b0, 8'h55, -1);
`endif

    // Held request: second start bit follows one idle cycle after the stop bit.
    tx_data  = 8'hA5;
    tx_valid = 1'b1;
    step();
    check_frame("hA5", 8'hA5, 1'b0, 1'b1, 8'h3C, -1);
    step();
    check_frame("h3C", 8'h3C, 1'b0, 1'b0, 8'h3C, -1);

    // Request pulsed mid-frame is dropped and never transmitted.
    tx_data  = 8'hC3;
    tx_valid = 1'b1;
    step();
    check_frame("iC3", 8'hC3, 1'b0, 1'b0, 8'hC3, 20);
    for (int i = 0; i < 20; i++) begin
      step();
      check($sformatf("noq_line_%0d", i), 32'(serial_out), 32'd1);
      check($sformatf("noq_ready_%0d", i), 32'(tx_ready), 32'd1);
    end

    // Reset at cycle 30 of a 0x00 frame, with a competing request on the same edge.
    tx_data  = 8'h00;
    tx_valid = 1'b1;
    step();
    tx_valid = 1'b0;
    for (int i = 0; i < 30; i++) begin
      check($sformatf("r00_line_%0d", i), 32'(serial_out), 32'd0);
      check($sformatf("r00_ready_%0d", i), 32'(tx_ready), 32'd0);
      step();
    end
    reset    = 1'b1;
    tx_valid = 1'b1;
    tx_data  = 8'h0F;
    step();
    check("midrst_line", 32'(serial_out), 32'd1);
    check("midrst_ready", 32'(tx_ready), 32'd1);
    check("midrst_busy", 32'(tx_busy), 32'd0);
    reset = 1'b0;
    step();
    check_frame("r0F", 8'h0F, 1'b0, 1'b0, 8'h0F, -1);

    step();
    check("final_line", 32'(serial_out), 32'd1);
    check("final_ready", 32'(tx_ready), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
